// File: rtl/clkdiv_prog.sv
// Runtime-programmable clock divider / tick generator with pulse and square outputs.
// Optional `CLKDIV_SYNC_CLR_EN adds a synchronous phase-clear input (sync_clr).
module clkdiv_prog #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned DIV_RESET = 2500
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             div_wr,
  input  logic [WIDTH-1:0] div_in,
`ifdef CLKDIV_SYNC_CLR_EN
  input  logic             sync_clr,
`endif
  output logic [WIDTH-1:0] div_cur,
  output logic             clkout,
  output logic             tc,
  output logic             div_err
);

  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_SQUARE = 1'b1
  } mode_e;

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_RESET);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
  localparam logic [WIDTH:0]   ONE_X   = (WIDTH+1)'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  mode_e            mode_q, mode_d;
  logic             clkout_q, clkout_d;
  logic             tc_q, tc_d;
  logic             err_q, err_d;

  logic             clr;
  logic             wr_ok;
  logic             wrap;
  logic [WIDTH-1:0] next_div;
  logic [WIDTH:0]   half;

`ifdef CLKDIV_SYNC_CLR_EN
  assign clr = sync_clr;
`else
  assign clr = 1'b0;
`endif

  always_comb begin
    wr_ok    = div_wr && (div_in >= TWO);
    wrap     = enable && (count_q == (div_q - ONE));
    // A valid write landing on the boundary edge takes priority over the pending one
    next_div = wr_ok ? div_in : (pend_v_q ? pend_q : div_q);
    half     = ({1'b0, div_q} + ONE_X) >> 1;

    count_d  = count_q;
    div_d    = div_q;
    pend_d   = wr_ok ? div_in : pend_q;
    pend_v_d = pend_v_q | wr_ok;
    mode_d   = mode_q;
    tc_d     = 1'b0;
    err_d    = div_wr && (div_in < TWO);
    clkout_d = (mode_q == MODE_SQUARE) ? clkout_q : 1'b0;

    if (clr) begin
      count_d  = '0;
      div_d    = next_div;
      pend_v_d = 1'b0;
      mode_d   = mode_e'(mode);
      clkout_d = 1'b0;
    end else if (wrap) begin
      count_d  = '0;
      div_d    = next_div;
      pend_v_d = 1'b0;
      mode_d   = mode_e'(mode);
      tc_d     = 1'b1;
      // Both modes are high in the count==0 cycle
      clkout_d = 1'b1;
    end else if (enable) begin
      count_d  = count_q + ONE;
      clkout_d = (mode_q == MODE_SQUARE) && (({1'b0, count_q} + ONE_X) < half);
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      div_q    <= DIV_RST;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      mode_q   <= MODE_PULSE;
      clkout_q <= 1'b0;
      tc_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      mode_q   <= mode_d;
      clkout_q <= clkout_d;
      tc_q     <= tc_d;
      err_q    <= err_d;
    end
  end

  assign div_cur = div_q;
  assign clkout  = clkout_q;
  assign tc      = tc_q;
  assign div_err = err_q;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Bench for clkdiv_prog: period-position model checked every cycle, plus directed literal checks.
module tb_clkdiv_prog;

  localparam int WIDTH = 12;
  localparam int DIVR  = 2500;

  logic             clkin;
  logic             reset;
  logic             enable;
  logic             mode;
  logic             div_wr;
  logic [WIDTH-1:0] div_in;
`ifdef CLKDIV_SYNC_CLR_EN
  logic             sync_clr;
`endif
  logic [WIDTH-1:0] div_cur;
  logic             clkout;
  logic             tc;
  logic             div_err;

  int errors = 0;
  int checks = 0;

  clkdiv_prog #(.WIDTH(WIDTH), .DIV_RESET(DIVR)) dut (
    .clkin   (clkin),
    .reset   (reset),
    .enable  (enable),
    .mode    (mode),
    .div_wr  (div_wr),
    .div_in  (div_in),
`ifdef CLKDIV_SYNC_CLR_EN
    .sync_clr(sync_clr),
`endif
    .div_cur (div_cur),
    .clkout  (clkout),
    .tc      (tc),
    .div_err (div_err)
  );

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a period is D enabled edges; position = enabled edges since period start.
  int m_d, m_pend, m_tot, m_start, m_tc, m_clk, m_err;
  bit m_sq;

  always @(posedge clkin or posedge reset) begin
    if (reset) begin
      m_d = DIVR; m_pend = 0; m_tot = 0; m_start = 0;
      m_tc = 0; m_clk = 0; m_err = 0; m_sq = 0;
    end else begin
      m_err = (div_wr && div_in < 2) ? 1 : 0;
      m_tc  = 0;
      if (div_wr && div_in >= 2) m_pend = int'(div_in);
`ifdef CLKDIV_SYNC_CLR_EN
      if (sync_clr) begin
        if (m_pend != 0) m_d = m_pend;
        m_pend = 0; m_sq = mode; m_start = m_tot; m_clk = 0;
      end else
`endif
      if (enable) begin
        m_tot++;
        if (m_tot - m_start == m_d) begin
          m_tc = 1;
          if (m_pend != 0) m_d = m_pend;
          m_pend = 0; m_sq = mode; m_start = m_tot;
        end
        m_clk = m_sq ? (((m_tot - m_start) < (m_d + 1) / 2) ? 1 : 0) : m_tc;
      end else begin
        m_clk = m_sq ? m_clk : 0;
      end
    end
  end

  always @(negedge clkin) begin
    check("model_tc", tc, m_tc);
    check("model_clkout", clkout, m_clk);
    check("model_div_err", div_err, m_err);
    check("model_div_cur", div_cur, m_d);
  end

  task automatic run(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic wr(input int v);
    div_wr = 1'b1; div_in = WIDTH'(v);
    run(1);
    div_wr = 1'b0;
  endtask

  int sq4[4] = '{1, 0, 0, 1};
  int sq5[5] = '{1, 1, 0, 0, 1};

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 1'b0; div_wr = 1'b0; div_in = '0;
`ifdef CLKDIV_SYNC_CLR_EN
    sync_clr = 1'b0;
`endif
    run(2);
    check("rst_div_cur", div_cur, 2500);
    check("rst_tc", tc, 0);
    check("rst_clkout", clkout, 0);
    check("rst_div_err", div_err, 0);
    reset = 1'b0; enable = 1'b1;

    // Default divisor: ticks at enabled edges 2500, 5000, 7500
    run(2499); check("t1_tc_2499", tc, 0);
    run(1);    check("t1_tc_2500", tc, 1); check("t1_clk_2500", clkout, 1);
    run(1);    check("t1_tc_2501", tc, 0);
    run(2499); check("t1_tc_5000", tc, 1);
    run(2500); check("t1_tc_7500", tc, 1); check("t1_div", div_cur, 2500);

    // Write 4 at count 1000, applied at the next boundary
    run(1000);
    wr(4);
    run(1498); check("t2_tc_9999", tc, 0); check("t2_div_old", div_cur, 2500);
    run(1);    check("t2_tc_10000", tc, 1); check("t2_div_new", div_cur, 4);
    run(3);    check("t2_tc_mid", tc, 0);
    run(1);    check("t2_tc_p4", tc, 1);

    // Square mode: D=4 then D=5
    mode = 1'b1;
    run(4); check("t3_sw_tc", tc, 1); check("t3_sw_clk", clkout, 1);
    for (int i = 0; i < 4; i++) begin
      run(1);
      check("t3_sq4_clk", clkout, sq4[i]);
      check("t3_sq4_tc", tc, int'(i == 3));
    end
    wr(5);
    run(3); check("t3_d5_tc", tc, 1); check("t3_d5_div", div_cur, 5);
    for (int i = 0; i < 5; i++) begin
      run(1);
      check("t3_sq5_clk", clkout, sq5[i]);
      check("t3_sq5_tc", tc, int'(i == 4));
    end

    // D=10 with enable low for 7 cycles mid-period
    wr(10);
    run(4); check("t5_div", div_cur, 10); check("t5_wrap", tc, 1);
    run(3); check("t5_clk_pos3", clkout, 1);
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      run(1);
      check("t5_hold_tc", tc, 0);
      check("t5_hold_clk", clkout, 1);
    end
    enable = 1'b1;
    run(6); check("t5_tc_pos9", tc, 0); check("t5_clk_pos9", clkout, 0);
    run(1); check("t5_tc_delayed", tc, 1);

    // Pulse mode, disabled output, invalid write keeps pending, wrap-cycle write
    mode = 1'b0;
    run(10); check("t4_pulse_tc", tc, 1); check("t4_pulse_clk", clkout, 1);
    enable = 1'b0;
    run(3); check("t4_dis_clk", clkout, 0); check("t4_dis_tc", tc, 0);
    enable = 1'b1;
    wr(6);
    wr(1); check("t4_err_hi", div_err, 1);
    run(1); check("t4_err_lo", div_err, 0);
    run(7); check("t4_pend6_tc", tc, 1); check("t4_pend6_div", div_cur, 6);
    wr(8);
    run(4);
    div_wr = 1'b1; div_in = WIDTH'(3);
    run(1); div_wr = 1'b0;
    check("t4_wrapwr_tc", tc, 1); check("t4_wrapwr_div", div_cur, 3);
    run(2); check("t4_d3_mid", tc, 0);
    run(1); check("t4_d3_tc", tc, 1);

    // Asynchronous reset mid-period with a pending write
    mode = 1'b1;
    run(3); check("t6_sq_wrap", tc, 1);
    wr(7); check("t6_clk_hi", clkout, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_tc", tc, 0);
    check("t6_async_clk", clkout, 0);
    check("t6_async_div", div_cur, 2500);
    check("t6_async_err", div_err, 0);
    run(2);
    reset = 1'b0; mode = 1'b0;
    run(100);
    wr(1); check("t6_err1", div_err, 1);
    wr(0); check("t6_err0", div_err, 1);
    run(1); check("t6_err_lo", div_err, 0);
    run(2396); check("t6_tc_2499", tc, 0);
    run(1); check("t6_tc_2500", tc, 1); check("t6_div_kept", div_cur, 2500);

`ifdef CLKDIV_SYNC_CLR_EN
    wr(4);
    mode = 1'b1;
    run(2);
    sync_clr = 1'b1;
    run(1); sync_clr = 1'b0;
    check("sc_tc", tc, 0); check("sc_clk", clkout, 0); check("sc_div", div_cur, 4);
    run(3); check("sc_tc_mid", tc, 0);
    run(1); check("sc_tc_d", tc, 1); check("sc_clk_d", clkout, 1);
`endif

    run(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
